// File: rtl/exu.sv
// Execute/write-back stage: one ALU op per issue, iterative shift-add MUL,
// drives the register file write port and keeps zero/carry/odd flags.
module exu #(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [AW-1:0] dst,
  output logic          busy,
  output logic          done,
  output logic          we,
  output logic [AW-1:0] wad,
  output logic [DW-1:0] wd,
  output logic          zf,
  output logic          cf,
  output logic          of
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SHR1 = 3'b100;
  localparam logic [2:0] OP_SHL1 = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_CMP  = 3'b111;

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

  state_t          state, state_nx;
  logic [2:0]      op_q;
  logic [AW-1:0]   dst_q;
  logic [2*DW-1:0] mcand, acc, acc_nx;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;
  logic            accept, mul_last;
  logic [DW:0]     alu;

  // WB also accepts, so single-cycle ops can issue back to back
  assign accept   = start && (state != MUL);
  assign mul_last = (state == MUL) && (cnt == LAST);
  assign acc_nx   = mplier[0] ? (acc + mcand) : acc;

  // Single-cycle ALU; the top bit is carry/borrow/shifted-out bit
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:         alu = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: alu = {1'b0, a} - {1'b0, b};
      OP_AND:         alu = {1'b0, a & b};
      OP_OR:          alu = {1'b0, a | b};
      OP_SHR1:        alu = {a[0], 1'b0, a[DW-1:1]};
      OP_SHL1:        alu = {a[DW-1], a[DW-2:0], 1'b0};
      default:        alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, WB: begin
        if (accept) state_nx = (op == OP_MUL) ? MUL : WB;
        else        state_nx = IDLE;
      end
      MUL:     if (mul_last) state_nx = WB;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL);
    done = (state == WB);
    we   = (state == WB) && (op_q != OP_CMP);
  end

  // Operands are captured at acceptance so later input changes or a
  // write-back to a source register cannot disturb the op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      dst_q  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      wd     <= '0;
      wad    <= '0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      of     <= 1'b0;
    end else if (accept) begin
      op_q  <= op;
      dst_q <= dst;
      if (op == OP_MUL) begin
        mcand  <= {{DW{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        wd  <= alu[DW-1:0];
        wad <= dst;
        cf  <= alu[DW];
        zf  <= (alu[DW-1:0] == '0);
        of  <= alu[0];
      end
    end else if (state == MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nx;
      cnt    <= cnt + CW'(1);
      if (mul_last) begin
        wd  <= acc_nx[DW-1:0];
        wad <= dst_q;
        cf  <= |acc_nx[2*DW-1:DW];
        zf  <= (acc_nx[DW-1:0] == '0);
        of  <= acc_nx[0];
      end
    end
  end

endmodule

// File: tb/tb_exu.sv
// Bench for exu: directed corner cases plus random ops checked against an
// arithmetic reference model of each operation.
module tb_exu;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] a, b;
  logic [AW-1:0] dst;
  logic          busy, done, we, zf, cf, of;
  logic [AW-1:0] wad;
  logic [DW-1:0] wd;

  int compared   = 0;
  int mismatched = 0;
  logic exp_zf, exp_cf, exp_of;

  always #5 clk = ~clk;

  exu #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dst(dst),
    .busy(busy), .done(done), .we(we), .wad(wad), .wd(wd),
    .zf(zf), .cf(cf), .of(of)
  );

  // Reference: {carry, result} computed with plain wide-integer arithmetic
  function automatic logic [DW:0] model(input logic [2:0] mop,
                                        input logic [DW-1:0] ma, mb);
    longint unsigned full = longint'(1) << DW;
    longint unsigned x = ma;
    longint unsigned y = mb;
    longint unsigned r;
    logic c;
    case (mop)
      3'd0:       begin r = x + y; c = (r >= full); r = r % full; end
      3'd1, 3'd7: begin c = (x < y); r = (x + full - y) % full; end
      3'd2:       begin r = x & y; c = 1'b0; end
      3'd3:       begin r = x | y; c = 1'b0; end
      3'd4:       begin r = x / 2; c = ((x % 2) == 1); end
      3'd5:       begin r = (x * 2) % full; c = (x >= full / 2); end
      default:    begin r = x * y; c = (r >= full); r = r % full; end
    endcase
    return {c, DW'(r)};
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkBit({tag, "_busy"}, busy, 1'b0);
    checkBit({tag, "_done"}, done, 1'b0);
    checkBit({tag, "_we"}, we, 1'b0);
    checkOutput({tag, "_wad"}, DW'(wad), '0);
    checkOutput({tag, "_wd"}, wd, '0);
    checkBit({tag, "_zf"}, zf, 1'b0);
    checkBit({tag, "_cf"}, cf, 1'b0);
    checkBit({tag, "_of"}, of, 1'b0);
  endtask

  task automatic drive(input logic [2:0] mop, input logic [DW-1:0] ma, mb,
                       input logic [AW-1:0] mdst);
    op = mop; a = ma; b = mb; dst = mdst; start = 1'b1;
  endtask

  // Issue one op at the next rising edge, then scramble the inputs
  task automatic applyStimulus(input logic [2:0] mop, input logic [DW-1:0] ma, mb,
                               input logic [AW-1:0] mdst);
    drive(mop, ma, mb, mdst);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = DW'($urandom); b = DW'($urandom);
    dst = AW'($urandom); op = 3'($urandom);
  endtask

  task automatic checkRetire(input string tag, input logic [2:0] mop,
                             input logic [DW-1:0] ma, mb, input logic [AW-1:0] mdst);
    logic [DW:0] e;
    e = model(mop, ma, mb);
    exp_zf = (e[DW-1:0] == '0);
    exp_cf = e[DW];
    exp_of = e[0];
    checkBit({tag, "_done"}, done, 1'b1);
    checkBit({tag, "_we"}, we, mop != 3'd7);
    checkBit({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_wd"}, wd, e[DW-1:0]);
    checkOutput({tag, "_wad"}, DW'(wad), DW'(mdst));
    checkBit({tag, "_zf"}, zf, exp_zf);
    checkBit({tag, "_cf"}, cf, exp_cf);
    checkBit({tag, "_of"}, of, exp_of);
  endtask

  task automatic checkIdleHold(input string tag);
    checkBit({tag, "_we_off"}, we, 1'b0);
    checkBit({tag, "_done_off"}, done, 1'b0);
    checkBit({tag, "_zf_hold"}, zf, exp_zf);
    checkBit({tag, "_cf_hold"}, cf, exp_cf);
    checkBit({tag, "_of_hold"}, of, exp_of);
  endtask

  // Full op: issue, follow the MUL iterations if any, check retirement and
  // the idle cycle after. poke injects an ADD start during cycle t+5.
  task automatic runOp(input string tag, input logic [2:0] mop,
                       input logic [DW-1:0] ma, mb, input logic [AW-1:0] mdst,
                       input bit poke);
    applyStimulus(mop, ma, mb, mdst);
    if (mop == 3'd6) begin
      for (int i = 1; i <= DW; i++) begin
        @(negedge clk);
        checkBit({tag, "_busy_iter"}, busy, 1'b1);
        checkBit({tag, "_we_iter"}, we, 1'b0);
        if (poke && i == 5) drive(3'd0, 16'h1111, 16'h2222, 2'd0);
        else start = 1'b0;
      end
    end
    @(negedge clk);
    checkRetire(tag, mop, ma, mb, mdst);
    @(negedge clk);
    checkIdleHold(tag);
  endtask

  initial begin
    logic [2:0]    rop;
    logic [DW-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; dst = '0;
    #1;
    checkReset("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    runOp("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 2'd2, 1'b0);

    // SHR1 then SHL1 issued on the very next edge
    drive(3'd4, 16'd27, 16'd0, 2'd1);
    @(posedge clk);
    #1;
    drive(3'd5, 16'd27, 16'd0, 2'd2);
    @(negedge clk);
    checkRetire("shr1", 3'd4, 16'd27, 16'd0, 2'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = DW'($urandom);
    @(negedge clk);
    checkRetire("shl1_b2b", 3'd5, 16'd27, 16'd0, 2'd2);
    @(negedge clk);
    checkIdleHold("shl1_b2b");

    runOp("mul_7x3", 3'd6, 16'd7, 16'd3, 2'd3, 1'b1);
    runOp("mul_ovf", 3'd6, 16'h0100, 16'h0100, 2'd1, 1'b0);
    runOp("cmp_5_9", 3'd7, 16'd5, 16'd9, 2'd2, 1'b0);

    // Reset in the middle of a multiply
    applyStimulus(3'd6, 16'd5, 16'd5, 2'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checkReset("rst_mid_mul");
    @(negedge clk);
    rst = 1'b0;
    repeat (DW + 2) begin
      @(negedge clk);
      checkBit("post_rst_we", we, 1'b0);
    end
    runOp("add_after_rst", 3'd0, 16'd2, 16'd2, 2'd1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = DW'($urandom);
      rb = DW'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) rb = DW'($urandom_range(0, 3));
      if (rop == 3'd6 && $urandom_range(0, 1) == 0) begin
        ra = DW'($urandom_range(0, 255));
        rb = DW'($urandom_range(0, 255));
      end
      runOp($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, AW'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
